note_envelope_player: RTL and testbench
=======================================

// Module: note_envelope_player
// PURPOSE
//  Consumes the note stream from the song reader (new_note/note/duration/metadata)
//  and plays one note at a time. Latches the note, counts its duration in beats,
//  and drives an attack/sustain/release amplitude envelope toward the sine/DAC
//  path. Pulses note_done when a note's duration expires.
// PARAMETERS
//  ATTACK_STEP   8'd16  amplitude increment per sample_tick during ATTACK (saturating)
//  RELEASE_STEP  8'd8   amplitude decrement per sample_tick during RELEASE (floor 0)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  play         in   1  1 = run; 0 = pause (freeze beat count and envelope)
//  new_note     in   1  one-cycle strobe: note/duration/metadata valid
//  note         in   6  note code; 0 = silence
//  duration     in   6  note length in beats
//  metadata     in   3  dynamics; peak amplitude = {metadata,5'b11111}
//  beat         in   1  one-cycle beat strobe (48 Hz)
//  sample_tick  in   1  one-cycle audio-sample strobe
//  note_out     out  6  latched note code
//  note_valid   out  1  1 when a nonzero note is sounding (state != IDLE, note_out != 0)
//  amplitude    out  8  current envelope amplitude
//  note_done    out  1  one-cycle pulse at duration expiry
//  busy         out  1  1 while state is ATTACK or SUSTAIN
// BEHAVIOUR
//  Reset: state=IDLE, note_out=0, note_valid=0, amplitude=0, note_done=0,
//   busy=0, beat_cnt=0, all latches cleared. Reset overrides every other input.
//  States: IDLE, ATTACK, SUSTAIN, RELEASE (registered; outputs registered).
//  Latch: new_note=1 in cycle t (any state, regardless of play) -> in t+1
//   note_out/dur/peak latched, beat_cnt=0, state=ATTACK, amplitude retained
//   (retrigger ramps from current level, no click to 0).
//  duration==0: latched, no ATTACK; note_done=1 in t+1, state goes to RELEASE.
//  Beat count: in ATTACK/SUSTAIN with play=1, each beat increments beat_cnt
//   (6-bit). The first countable beat is one arriving strictly after the latch
//   cycle. When the increment makes beat_cnt==dur: note_done=1 next cycle,
//   state -> RELEASE.
//  ATTACK: on sample_tick && play: amplitude = min(amplitude+ATTACK_STEP, peak)
//   (9-bit intermediate, no wrap); amplitude reaching peak -> SUSTAIN.
//   If amplitude > peak on entry (retrigger louder->softer), clamp to peak
//   on the first tick and go to SUSTAIN.
//  SUSTAIN: amplitude held at peak.
//  RELEASE: on sample_tick && play: amplitude = max(amplitude-RELEASE_STEP,0);
//   amplitude reaching 0 -> IDLE.
//  IDLE: amplitude=0; only new_note leaves IDLE.
//  note=0 (rest): timed exactly like a note; amplitude target forced to 0;
//   note_valid=0 throughout.
//  Pause (play=0): beat, sample_tick ignored; state, beat_cnt, amplitude
//   frozen; new_note still latches (applied on resume).
//  Simultaneous new_note and expiring beat: new_note wins; old note's
//   note_done suppressed; counting restarts for new note.
//  note_done width exactly 1 cycle; never asserted in IDLE or RELEASE
//   except the duration==0 case above.
// TESTING
//  T1 reset mid-SUSTAIN -> next cycle all outputs 0, state IDLE.
//  T2 new_note note=6'd20 dur=3 meta=3'd7, beat every 10 cycles ->
//   amplitude ramps 16,32..255 on ticks; note_done single pulse the cycle after
//   3rd beat; amplitude falls by 8/tick to 0; note_valid drops on IDLE.
//  T3 dur=0 -> note_done one cycle after new_note, no ATTACK.
//  T4 play=0 for 50 cycles mid-note with beats/ticks -> beat_cnt, amplitude
//   unchanged; completion delayed by exactly the paused beats.
//  T5 new_note coincident with expiring beat -> no note_done, new note_out,
//   beat_cnt=0, state ATTACK.
//  T6 note=0 dur=2 -> note_valid=0, amplitude stays 0, note_done after 2nd beat.

Source files
------------

// File: rtl/note_envelope_player.sv
// Plays one note at a time from the song-reader stream: latches the note, counts beats,
// and shapes an attack/sustain/release amplitude envelope for the sine/DAC path.
module note_envelope_player #(
  parameter logic [7:0] ATTACK_STEP  = 8'd16,
  parameter logic [7:0] RELEASE_STEP = 8'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       new_note,
  input  logic [5:0] note,
  input  logic [5:0] duration,
  input  logic [2:0] metadata,
  input  logic       beat,
  input  logic       sample_tick,
  output logic [5:0] note_out,
  output logic       note_valid,
  output logic [7:0] amplitude,
  output logic       note_done,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} state_e;

  state_e     state_q, state_d;
  logic [5:0] dur_q, dur_d;
  logic [7:0] peak_q, peak_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] note_d;
  logic [7:0] amp_d;
  logic       done_d;
  logic       valid_d;
  logic       busy_d;
  logic [8:0] amp_up;

  assign amp_up = {1'b0, amplitude} + {1'b0, ATTACK_STEP};

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    note_d  = note_out;
    amp_d   = amplitude;
    done_d  = 1'b0;
    if (new_note) begin
      // Latch wins over pause and over an expiring beat; amplitude is kept so a
      // retrigger ramps from the current level instead of clicking to zero.
      note_d  = note;
      dur_d   = duration;
      peak_d  = (note == 6'd0) ? 8'd0 : {metadata, 5'b11111};
      cnt_d   = 6'd0;
      state_d = (duration == 6'd0) ? StRelease : StAttack;
      done_d  = (duration == 6'd0);
    end else if (play) begin
      unique case (state_q)
        StIdle: amp_d = 8'd0;
        StAttack, StSustain: begin
          if (state_q == StSustain) begin
            amp_d = peak_q;
          end else if (sample_tick) begin
            // Also clamps a level left above a softer peak by a retrigger.
            if (amp_up >= {1'b0, peak_q}) begin
              amp_d   = peak_q;
              state_d = StSustain;
            end else begin
              amp_d = amp_up[7:0];
            end
          end
          if (beat) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_d == dur_q) begin
              done_d  = 1'b1;
              state_d = StRelease;
            end
          end
        end
        StRelease: begin
          if (sample_tick) begin
            if (amplitude <= RELEASE_STEP) begin
              amp_d   = 8'd0;
              state_d = StIdle;
            end else begin
              amp_d = amplitude - RELEASE_STEP;
            end
          end
        end
      endcase
    end
    valid_d = (state_d != StIdle) && (note_d != 6'd0);
    busy_d  = (state_d == StAttack) || (state_d == StSustain);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      dur_q      <= 6'd0;
      peak_q     <= 8'd0;
      cnt_q      <= 6'd0;
      note_out   <= 6'd0;
      amplitude  <= 8'd0;
      note_done  <= 1'b0;
      note_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dur_q      <= dur_d;
      peak_q     <= peak_d;
      cnt_q      <= cnt_d;
      note_out   <= note_d;
      amplitude  <= amp_d;
      note_done  <= done_d;
      note_valid <= valid_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_note_envelope_player.sv
// Directed bench for note_envelope_player: ramps, duration expiry, pause, retrigger, rests.
module tb_note_envelope_player;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b1;
  logic       new_note = 1'b0;
  logic [5:0] note = 6'd0;
  logic [5:0] duration = 6'd0;
  logic [2:0] metadata = 3'd0;
  logic       beat = 1'b0;
  logic       sample_tick = 1'b0;
  logic [5:0] note_out;
  logic       note_valid;
  logic [7:0] amplitude;
  logic       note_done;
  logic       busy;

  int vectors = 0;
  int errors = 0;

  note_envelope_player dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .new_note   (new_note),
    .note       (note),
    .duration   (duration),
    .metadata   (metadata),
    .beat       (beat),
    .sample_tick(sample_tick),
    .note_out   (note_out),
    .note_valid (note_valid),
    .amplitude  (amplitude),
    .note_done  (note_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic b, input logic t);
    beat = b;
    sample_tick = t;
    cyc();
    beat = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic start(input logic [5:0] n, input logic [5:0] d, input logic [2:0] m,
                       input logic b);
    new_note = 1'b1;
    note = n;
    duration = d;
    metadata = m;
    beat = b;
    cyc();
    new_note = 1'b0;
    beat = 1'b0;
  endtask

  initial begin
    int exp_amp;
    logic seen;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_note_out", note_out, 0);
    chk("rst_amp", amplitude, 0);
    chk("rst_valid", note_valid, 0);
    chk("rst_done", note_done, 0);
    chk("rst_busy", busy, 0);

    // T2: full note, peak 255, three beats
    start(6'd20, 6'd3, 3'd7, 1'b0);
    chk("t2_note_out", note_out, 20);
    chk("t2_valid", note_valid, 1);
    chk("t2_busy", busy, 1);
    chk("t2_amp0", amplitude, 0);
    for (int i = 1; i <= 16; i++) begin
      pulse(1'b0, 1'b1);
      exp_amp = (16 * i > 255) ? 255 : 16 * i;
      chk("t2_attack", amplitude, exp_amp);
    end
    pulse(1'b0, 1'b1);
    chk("t2_sustain", amplitude, 255);
    pulse(1'b1, 1'b0);
    chk("t2_beat1", note_done, 0);
    pulse(1'b1, 1'b0);
    chk("t2_beat2", note_done, 0);
    pulse(1'b1, 1'b0);
    chk("t2_done", note_done, 1);
    chk("t2_busy_rel", busy, 0);
    chk("t2_valid_rel", note_valid, 1);
    cyc();
    chk("t2_done_width", note_done, 0);
    for (int i = 1; i <= 32; i++) begin
      pulse(1'b0, 1'b1);
      exp_amp = (255 - 8 * i > 0) ? 255 - 8 * i : 0;
      chk("t2_release", amplitude, exp_amp);
    end
    chk("t2_valid_idle", note_valid, 0);

    // T3: zero duration
    start(6'd5, 6'd0, 3'd3, 1'b0);
    chk("t3_done", note_done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_valid", note_valid, 1);
    chk("t3_amp", amplitude, 0);
    cyc();
    chk("t3_done_width", note_done, 0);
    pulse(1'b0, 1'b1);
    chk("t3_idle_valid", note_valid, 0);

    // T4: pause mid-note, peak 63
    start(6'd9, 6'd2, 3'd1, 1'b0);
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1);
    chk("t4_peak", amplitude, 63);
    pulse(1'b1, 1'b0);
    chk("t4_beat1", note_done, 0);
    play = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      beat = (i % 10 == 3);
      sample_tick = (i % 10 == 7);
      cyc();
      if (note_done) seen = 1'b1;
    end
    beat = 1'b0;
    sample_tick = 1'b0;
    chk("t4_pause_done", seen, 0);
    chk("t4_pause_amp", amplitude, 63);
    chk("t4_pause_busy", busy, 1);
    play = 1'b1;
    pulse(1'b1, 1'b0);
    chk("t4_resume_done", note_done, 1);

    // T5: new note coincident with expiring beat
    start(6'd12, 6'd1, 3'd2, 1'b0);
    chk("t5_retrig_amp", amplitude, 63);
    start(6'd33, 6'd4, 3'd7, 1'b1);
    chk("t5_no_done", note_done, 0);
    chk("t5_note_out", note_out, 33);
    chk("t5_busy", busy, 1);
    pulse(1'b0, 1'b1);
    chk("t5_ramp_from_level", amplitude, 79);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0);
      chk("t5_count", note_done, 0);
    end
    pulse(1'b1, 1'b0);
    chk("t5_done", note_done, 1);

    // Retrigger louder -> softer clamps on first tick
    start(6'd7, 6'd5, 3'd1, 1'b0);
    pulse(1'b0, 1'b1);
    chk("clamp_amp", amplitude, 63);
    chk("clamp_busy", busy, 1);

    // T1: reset mid-sustain
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t1_note_out", note_out, 0);
    chk("t1_amp", amplitude, 0);
    chk("t1_valid", note_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_done", note_done, 0);

    // T6: rest
    start(6'd0, 6'd2, 3'd7, 1'b0);
    chk("t6_valid", note_valid, 0);
    chk("t6_busy", busy, 1);
    pulse(1'b0, 1'b1);
    chk("t6_amp", amplitude, 0);
    pulse(1'b1, 1'b0);
    chk("t6_beat1", note_done, 0);
    pulse(1'b1, 1'b0);
    chk("t6_done", note_done, 1);
    chk("t6_valid_rel", note_valid, 0);
    cyc();
    chk("t6_done_width", note_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
